// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage port: one word request at a time,
// configurable access latency, combinational stall request and flush abort.
module dmem_responder #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] data_i,
    input  logic        flush_i,
    output logic [31:0] data_o,
    output logic        stallreq_o,
    output logic        bus_err_o
);
    localparam int CNT_W = (WAIT_CYCLES < 2) ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic               r_we;
    logic [31:0]        r_addr, r_data;
    logic [3:0]         r_sel;
    logic [31:0]        r_mem [2**ADDR_W];

    logic               w_accept, w_access, w_in_range, w_acc_we;
    logic [31:0]        w_acc_addr, w_acc_data;
    logic [3:0]         w_acc_sel;
    logic [ADDR_W-1:0]  w_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_accept   = 1'b0;
        w_access   = 1'b0;
        stallreq_o = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (ce_i && !flush_i) begin
                    w_accept   = 1'b1;
                    stallreq_o = 1'b1;
                    w_cnt_next = CNT_W'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        w_access = 1'b1;
                        w_next   = S_DONE;
                    end else begin
                        w_next   = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                stallreq_o = 1'b1;
                if (flush_i) begin
                    w_next = S_IDLE;
                end else if (r_cnt > CNT_W'(1)) begin
                    w_cnt_next = r_cnt - CNT_W'(1);
                end else begin
                    w_access = 1'b1;
                    w_next   = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        // Reset must abandon any access and drop the stall without a clock edge.
        if (rst) begin
            stallreq_o = 1'b0;
            w_access   = 1'b0;
            w_accept   = 1'b0;
        end
    end

    // Zero-latency accesses happen in IDLE straight from the port.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_acc_we   = we_i;
            w_acc_addr = addr_i;
            w_acc_sel  = sel_i;
            w_acc_data = data_i;
        end else begin
            w_acc_we   = r_we;
            w_acc_addr = r_addr;
            w_acc_sel  = r_sel;
            w_acc_data = r_data;
        end
        w_in_range = (w_acc_addr[31:ADDR_W+2] == '0);
        w_idx      = w_acc_addr[ADDR_W+1:2];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_sel     <= '0;
            r_data    <= '0;
            data_o    <= '0;
            bus_err_o <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we   <= we_i;
                r_addr <= addr_i;
                r_sel  <= sel_i;
                r_data <= data_i;
            end
            bus_err_o <= w_access && !w_in_range;
            if (w_access && !w_acc_we)
                data_o <= w_in_range ? r_mem[w_idx] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_access && w_acc_we && w_in_range) begin
            for (int k = 0; k < 4; k++)
                if (w_acc_sel[k]) r_mem[w_idx][8*k +: 8] <= w_acc_data[8*k +: 8];
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 instance and a
// WAIT_CYCLES=0 instance sharing clock, reset and request fields.
module tb_dmem_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce_a = 1'b0, ce_b = 1'b0, we = 1'b0, flush = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  sel = '0;
    logic [31:0] do_a, do_b;
    logic        st_a, st_b, err_a, err_b;
    int          n_checks = 0, n_fail = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .ce_i(ce_a), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .flush_i(flush), .data_o(do_a), .stallreq_o(st_a), .bus_err_o(err_a));

    dmem_responder #(.ADDR_W(12), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .ce_i(ce_b), .we_i(we), .addr_i(addr), .sel_i(sel),
        .data_i(wdata), .flush_i(flush), .data_o(do_b), .stallreq_o(st_b), .bus_err_o(err_b));

    // Drives one request after a rising edge, holds it until the first
    // non-stalled cycle (DONE), samples outputs there, then drops ce after the next edge.
    task automatic access(input bit which, input bit w, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output int stalls, output logic [31:0] rd, output logic er);
        bit done;
        @(posedge clk); #1;
        we = w; addr = a; sel = s; wdata = d;
        if (which) ce_b = 1'b1; else ce_a = 1'b1;
        stalls = 0; done = 1'b0; rd = '0; er = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if ((which ? st_b : st_a) === 1'b1) begin
                stalls++;
                @(posedge clk);
            end else begin
                rd = which ? do_b : do_a;
                er = which ? err_b : err_a;
                done = 1'b1;
            end
        end
        if (!done) stalls = 99;
        @(posedge clk); #1;
        ce_a = 1'b0; ce_b = 1'b0; we = 1'b0;
    endtask

    task automatic test_reset;
        ce_a = 1'b1;
        #2;
        n_checks++; if (st_a !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", st_a); end
        n_checks++; if (do_a !== 32'h0) begin n_fail++; $display("FAIL reset_data got=%h exp=00000000", do_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err_a); end
        ce_a = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (st_a !== 1'b0) begin n_fail++; $display("FAIL idle_stall got=%b exp=0", st_a); end
    endtask

    task automatic test_write_read;
        int st; logic [31:0] rd; logic er;
        access(0, 1, 32'h10, 4'hF, 32'hDEADBEEF, st, rd, er);
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL wr_stalls got=%0d exp=3", st); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL wr_err got=%b exp=0", er); end
        access(0, 0, 32'h10, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL rd_stalls got=%0d exp=3", st); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got=%h exp=deadbeef", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL rd_err got=%b exp=0", er); end
    endtask

    task automatic test_byte_lane;
        int st; logic [31:0] rd; logic er;
        access(0, 1, 32'h10, 4'hF, 32'h11223344, st, rd, er);
        access(0, 1, 32'h12, 4'b0010, 32'hAAAAAAAA, st, rd, er);
        access(0, 0, 32'h10, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL lane_data got=%h exp=1122aa44", rd); end
        access(0, 1, 32'h10, 4'b1001, 32'h99999999, st, rd, er);
        n_checks++; if (rd !== 32'h1122AA44) begin n_fail++; $display("FAIL wr_keeps_data_o got=%h exp=1122aa44", rd); end
        access(0, 1, 32'h10, 4'b0000, 32'hFFFFFFFF, st, rd, er);
        access(0, 0, 32'h10, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h9922AA99) begin n_fail++; $display("FAIL lane_sel0 got=%h exp=9922aa99", rd); end
    endtask

    task automatic test_flush_wait;
        int st; logic [31:0] rd; logic er;
        access(0, 1, 32'h20, 4'hF, 32'h0, st, rd, er);
        @(posedge clk); #1;
        ce_a = 1'b1; we = 1'b1; addr = 32'h20; sel = 4'hF; wdata = 32'h5;
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        n_checks++; if (st_a !== 1'b1) begin n_fail++; $display("FAIL flush_wait_stall got=%b exp=1", st_a); end
        @(posedge clk); #1;
        flush = 1'b0; ce_a = 1'b0; we = 1'b0;
        @(negedge clk);
        n_checks++; if (st_a !== 1'b0) begin n_fail++; $display("FAIL flush_drop got=%b exp=0", st_a); end
        // Request together with flush in IDLE is rejected.
        ce_a = 1'b1; flush = 1'b1;
        #1;
        n_checks++; if (st_a !== 1'b0) begin n_fail++; $display("FAIL flush_idle got=%b exp=0", st_a); end
        @(posedge clk); #1 ce_a = 1'b0; flush = 1'b0;
        access(0, 0, 32'h20, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL flush_mem got=%h exp=00000000", rd); end
        n_checks++; if (st !== 3) begin n_fail++; $display("FAIL flush_after_stalls got=%0d exp=3", st); end
    endtask

    task automatic test_latch_and_done_flush;
        int st; logic [31:0] rd; logic er;
        access(0, 1, 32'h28, 4'hF, 32'h0, st, rd, er);
        @(posedge clk); #1;
        ce_a = 1'b1; we = 1'b1; addr = 32'h24; sel = 4'hF; wdata = 32'h77;
        @(posedge clk); #1;
        addr = 32'h28; wdata = 32'h99; sel = 4'h0;
        @(posedge clk);
        @(posedge clk); #1 flush = 1'b1;
        @(negedge clk);
        n_checks++; if (st_a !== 1'b0) begin n_fail++; $display("FAIL done_stall got=%b exp=0", st_a); end
        @(posedge clk); #1;
        flush = 1'b0; ce_a = 1'b0; we = 1'b0;
        access(0, 0, 32'h24, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h77) begin n_fail++; $display("FAIL done_flush_commit got=%h exp=00000077", rd); end
        access(0, 0, 32'h28, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL latch_ignore got=%h exp=00000000", rd); end
    endtask

    task automatic test_out_of_range;
        int st; logic [31:0] rd; logic er;
        access(0, 1, 32'h0, 4'hF, 32'hCAFEF00D, st, rd, er);
        access(0, 0, 32'h4000, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL oob_data got=%h exp=00000000", rd); end
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_err got=%b exp=1", er); end
        access(0, 1, 32'h4000, 4'hF, 32'hFFFFFFFF, st, rd, er);
        n_checks++; if (er !== 1'b1) begin n_fail++; $display("FAIL oob_wr_err got=%b exp=1", er); end
        @(negedge clk);
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL oob_err_clear got=%b exp=0", err_a); end
        access(0, 0, 32'h0, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL oob_word0 got=%h exp=cafef00d", rd); end
        n_checks++; if (er !== 1'b0) begin n_fail++; $display("FAIL inrange_err got=%b exp=0", er); end
    endtask

    task automatic test_back_to_back;
        int st; logic [31:0] rd; logic er;
        access(1, 1, 32'h0, 4'hF, 32'hA0A0A0A0, st, rd, er);
        n_checks++; if (st !== 1) begin n_fail++; $display("FAIL wc0_stalls got=%0d exp=1", st); end
        access(1, 1, 32'h4, 4'hF, 32'hB1B1B1B1, st, rd, er);
        @(posedge clk); #1;
        ce_b = 1'b1; we = 1'b0; addr = 32'h0; sel = 4'hF;
        @(negedge clk);
        n_checks++; if (st_b !== 1'b1) begin n_fail++; $display("FAIL b2b_idle1 got=%b exp=1", st_b); end
        @(negedge clk);
        n_checks++; if (st_b !== 1'b0) begin n_fail++; $display("FAIL b2b_done1 got=%b exp=0", st_b); end
        n_checks++; if (do_b !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL b2b_data1 got=%h exp=a0a0a0a0", do_b); end
        @(posedge clk); #1 addr = 32'h4;
        @(negedge clk);
        n_checks++; if (st_b !== 1'b1) begin n_fail++; $display("FAIL b2b_idle2 got=%b exp=1", st_b); end
        @(negedge clk);
        n_checks++; if (st_b !== 1'b0) begin n_fail++; $display("FAIL b2b_done2 got=%b exp=0", st_b); end
        n_checks++; if (do_b !== 32'hB1B1B1B1) begin n_fail++; $display("FAIL b2b_data2 got=%h exp=b1b1b1b1", do_b); end
        @(posedge clk); #1 ce_b = 1'b0;
    endtask

    task automatic test_reset_mid_wait;
        int st; logic [31:0] rd; logic er;
        access(0, 1, 32'h40, 4'hF, 32'h0, st, rd, er);
        access(0, 0, 32'h10, 4'hF, 32'h0, st, rd, er);
        @(posedge clk); #1;
        ce_a = 1'b1; we = 1'b1; addr = 32'h40; sel = 4'hF; wdata = 32'h55;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        n_checks++; if (st_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_stall got=%b exp=0", st_a); end
        n_checks++; if (do_a !== 32'h0) begin n_fail++; $display("FAIL rst_async_data got=%h exp=00000000", do_a); end
        n_checks++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL rst_async_err got=%b exp=0", err_a); end
        ce_a = 1'b0; we = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        access(0, 0, 32'h40, 4'hF, 32'h0, st, rd, er);
        n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL rst_mem got=%h exp=00000000", rd); end
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_byte_lane;
        test_flush_wait;
        test_latch_and_done_flush;
        test_out_of_range;
        test_back_to_back;
        test_reset_mid_wait;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
